// File: rtl/reaction_score_ctrl_pkg.sv
// Shared definitions for the reaction-time score controller.
// Holds the FSM state encoding, leader codes, the saturation value and a
// helper that turns the compare result (total0 - total1) into a leader code.
package reaction_score_ctrl_pkg;

  localparam int DATA_W = 15;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    ADD   = 3'd2,
    ACK   = 3'd3,
    CMP   = 3'd4
  } state_t;

  localparam logic [1:0] LEAD_TIE = 2'b00;
  localparam logic [1:0] LEAD_P0  = 2'b01;
  localparam logic [1:0] LEAD_P1  = 2'b10;

  localparam logic [DATA_W-1:0] SAT_MAX = 15'h7FFF;

  // total0 + ~total1 + 1: no carry means a borrow, so total0 < total1.
  function automatic logic [1:0] lead_code(input logic cout,
                                           input logic [DATA_W-1:0] diff);
    if (!cout)
      return LEAD_P0;
    else if (diff == '0)
      return LEAD_TIE;
    else
      return LEAD_P1;
  endfunction

endpackage

// File: rtl/reaction_score_ctrl_if.sv
// Requester handshake bundle for the two player reaction timers.
// master: timer side (drives req/time, receives ack).
// slave : score controller side (receives req/time, drives ack).
interface reaction_score_ctrl_if;
  import reaction_score_ctrl_pkg::*;

  logic              req0;
  logic [DATA_W-1:0] time0;
  logic              ack0;
  logic              req1;
  logic [DATA_W-1:0] time1;
  logic              ack1;

  modport master (output req0, time0, req1, time1, input ack0, ack1);
  modport slave  (input req0, time0, req1, time1, output ack0, ack1);
endinterface

// File: rtl/reaction_score_ctrl_full_adder_15bit.sv
// 15-bit ripple-carry adder with carry-in and carry-out exposed.
// Ports: a, b operands; cin carry-in; sum result; cout carry out of bit 14;
// overflow two's-complement overflow flag (carry into MSB xor carry out).
module full_adder_15bit (
  input  logic [14:0] a,
  input  logic [14:0] b,
  input  logic        cin,
  output logic [14:0] sum,
  output logic        cout,
  output logic        overflow
);

  logic [15:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 15; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout     = c[15];
  assign overflow = c[15] ^ c[14];

endmodule

// File: rtl/reaction_score_ctrl.sv
// Reaction-time score controller.
// Time-shares one 15-bit adder between two player requesters: accumulates
// each accepted round time into a saturating per-player total, then reuses
// the adder as a subtractor to decide the leader (lower total wins).
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   clear             synchronous new-game clear (one cycle)
//   bus               requester handshake (req/time in, ack pulse out)
//   total0/1          accumulated times, saturating at 0x7FFF
//   count0/1          rounds accumulated, capped at MAX_ROUNDS
//   sat0/1            sticky saturation flags
//   leader            00 tie, 01 player 0 ahead, 10 player 1 ahead
//   busy              FSM not in IDLE
//   done              both players reached MAX_ROUNDS
module reaction_score_ctrl
  import reaction_score_ctrl_pkg::*;
#(
  parameter int MAX_ROUNDS = 5,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  reaction_score_ctrl_if.slave  bus,
  output logic [DATA_W-1:0]     total0,
  output logic [DATA_W-1:0]     total1,
  output logic [CNT_W-1:0]      count0,
  output logic [CNT_W-1:0]      count1,
  output logic                  sat0,
  output logic                  sat1,
  output logic [1:0]            leader,
  output logic                  busy,
  output logic                  done
);

  state_t state, state_nxt;

  logic gnt;       // player currently being served
  logic last_gnt;  // player served most recently; resets to 1 so player 0 wins first tie
  logic arb_gnt;
  logic cnt_full;

  logic [DATA_W-1:0] op_a_p0, op_b_p0;
  logic [DATA_W-1:0] res_sum_p1;
  logic              res_cout_p1;

  logic [DATA_W-1:0] add_a, add_b, add_sum;
  logic              add_cin, add_cout;

  // Round-robin: a lone requester wins, otherwise the player not served last.
  always_comb begin
    arb_gnt = 1'b0;
    if (bus.req0 && bus.req1)
      arb_gnt = ~last_gnt;
    else if (bus.req1)
      arb_gnt = 1'b1;
  end

  assign cnt_full = ((gnt ? count1 : count0) == CNT_W'(MAX_ROUNDS));

  // The single adder sees the registered accumulate operands except in CMP,
  // where it computes total0 - total1 as total0 + ~total1 + 1.
  always_comb begin
    add_a   = op_a_p0;
    add_b   = op_b_p0;
    add_cin = 1'b0;
    if (state == CMP) begin
      add_a   = total0;
      add_b   = ~total1;
      add_cin = 1'b1;
    end
  end

  full_adder_15bit u_adder (
    .a        (add_a),
    .b        (add_b),
    .cin      (add_cin),
    .sum      (add_sum),
    .cout     (add_cout),
    .overflow ()
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else if (clear)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req0 || bus.req1) state_nxt = GRANT;
      GRANT:   state_nxt = cnt_full ? ACK : ADD;
      ADD:     state_nxt = ACK;
      ACK:     state_nxt = CMP;
      CMP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // An aborting clear suppresses the ack of the in-flight request.
  assign bus.ack0 = (state == ACK) && !gnt && !clear;
  assign bus.ack1 = (state == ACK) &&  gnt && !clear;
  assign busy     = (state != IDLE);
  assign done     = (count0 == CNT_W'(MAX_ROUNDS)) && (count1 == CNT_W'(MAX_ROUNDS));

  // Stage p0: operand capture in GRANT. Stage p1: adder result capture in ADD.
  always_ff @(posedge clk) begin
    if (state == GRANT) begin
      op_a_p0 <= gnt ? total1 : total0;
      op_b_p0 <= gnt ? bus.time1 : bus.time0;
    end
    if (state == ADD) begin
      res_sum_p1  <= add_sum;
      res_cout_p1 <= add_cout;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      total0   <= '0;
      total1   <= '0;
      count0   <= '0;
      count1   <= '0;
      sat0     <= 1'b0;
      sat1     <= 1'b0;
      leader   <= LEAD_TIE;
    end else if (clear) begin
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      total0   <= '0;
      total1   <= '0;
      count0   <= '0;
      count1   <= '0;
      sat0     <= 1'b0;
      sat1     <= 1'b0;
      leader   <= LEAD_TIE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            gnt      <= arb_gnt;
            last_gnt <= arb_gnt;
          end
        end
        ACK: begin
          // A full counter means this was the skip path: ack only.
          if (!cnt_full) begin
            if (!gnt) begin
              total0 <= (res_cout_p1 || sat0) ? SAT_MAX : res_sum_p1;
              sat0   <= sat0 | res_cout_p1;
              count0 <= count0 + CNT_W'(1);
            end else begin
              total1 <= (res_cout_p1 || sat1) ? SAT_MAX : res_sum_p1;
              sat1   <= sat1 | res_cout_p1;
              count1 <= count1 + CNT_W'(1);
            end
          end
        end
        CMP:     leader <= lead_code(add_cout, add_sum);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_score_ctrl.sv
module tb_reaction_score_ctrl;
  import reaction_score_ctrl_pkg::*;

  localparam int MAXR = 5;
  localparam int CW   = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           clear = 1'b0;
  logic [14:0]    total0, total1;
  logic [CW-1:0]  count0, count1;
  logic           sat0, sat1, busy, done;
  logic [1:0]     leader;

  reaction_score_ctrl_if bus ();

  reaction_score_ctrl #(.MAX_ROUNDS(MAXR), .CNT_W(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .bus    (bus),
    .total0 (total0),
    .total1 (total1),
    .count0 (count0),
    .count1 (count1),
    .sat0   (sat0),
    .sat1   (sat1),
    .leader (leader),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            p;
    bit            skip;
    logic [14:0]   tot0, tot1;
    logic [CW-1:0] c0, c1;
    logic          s0, s1;
    logic [1:0]    lead;
    logic          dn;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;

  logic [14:0] m_tot[2];
  int          m_cnt[2];
  bit          m_sat[2];
  bit          m_last;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_tot[i] = '0;
      m_cnt[i] = 0;
      m_sat[i] = 1'b0;
    end
    m_last = 1'b1;
  endfunction

  function automatic exp_t predict(input bit p, input logic [14:0] t);
    exp_t e;
    logic [15:0] s;
    e.p    = p;
    e.skip = (m_cnt[p] == MAXR);
    if (!e.skip) begin
      s = {1'b0, m_tot[p]} + {1'b0, t};
      if (m_sat[p] || s > 16'h7FFF) begin
        m_tot[p] = 15'h7FFF;
        m_sat[p] = 1'b1;
      end else begin
        m_tot[p] = s[14:0];
      end
      m_cnt[p]++;
    end
    m_last = p;
    e.tot0 = m_tot[0];
    e.tot1 = m_tot[1];
    e.c0   = CW'(m_cnt[0]);
    e.c1   = CW'(m_cnt[1]);
    e.s0   = m_sat[0];
    e.s1   = m_sat[1];
    if (m_tot[0] < m_tot[1])       e.lead = 2'b01;
    else if (m_tot[0] == m_tot[1]) e.lead = 2'b00;
    else                           e.lead = 2'b10;
    e.dn = (m_cnt[0] == MAXR) && (m_cnt[1] == MAXR);
    return e;
  endfunction

  task automatic do_reset();
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.time0 = '0; bus.time1 = '0;
    clear = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    sb.delete();
  endtask

  // Drives one or two requests, pushes the predicted results in predicted
  // grant order, then pops and compares as each ack appears.
  task automatic serve(input bit r0, input bit r1,
                       input logic [14:0] t0, input logic [14:0] t1);
    exp_t e;
    int   n;
    int   due;
    if (r0 && r1) begin
      if (m_last) begin
        sb.push_back(predict(1'b0, t0));
        sb.push_back(predict(1'b1, t1));
      end else begin
        sb.push_back(predict(1'b1, t1));
        sb.push_back(predict(1'b0, t0));
      end
    end else if (r0) sb.push_back(predict(1'b0, t0));
    else if (r1)     sb.push_back(predict(1'b1, t1));
    bus.req0 = r0; bus.time0 = t0; bus.req1 = r1; bus.time1 = t1;
    n   = 0;
    due = (sb.size() > 0) ? (sb[0].skip ? 2 : 3) : 0;
    while (sb.size() > 0 && n < 40) begin
      @(posedge clk); #1; n++;
      if (bus.ack0 || bus.ack1) begin
        e = sb.pop_front();
        nchk++;
        if (bus.ack1 !== logic'(e.p) || (bus.ack0 && bus.ack1)) begin
          nerr++; $display("FAIL grant: ack0=%b ack1=%b want player %0d", bus.ack0, bus.ack1, e.p);
        end
        nchk++;
        if (n != due) begin
          nerr++; $display("FAIL ack_latency: got cycle %0d want %0d", n, due);
        end
        if (e.p) bus.req1 = 1'b0; else bus.req0 = 1'b0;
        @(posedge clk); #1; n++;
        nchk++;
        if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || busy !== 1'b1) begin
          nerr++; $display("FAIL ack_pulse: ack0=%b ack1=%b busy=%b want 0 0 1", bus.ack0, bus.ack1, busy);
        end
        nchk++;
        if (total0 !== e.tot0 || total1 !== e.tot1) begin
          nerr++; $display("FAIL totals: got %h/%h want %h/%h", total0, total1, e.tot0, e.tot1);
        end
        nchk++;
        if (count0 !== e.c0 || count1 !== e.c1) begin
          nerr++; $display("FAIL counts: got %0d/%0d want %0d/%0d", count0, count1, e.c0, e.c1);
        end
        nchk++;
        if (sat0 !== e.s0 || sat1 !== e.s1) begin
          nerr++; $display("FAIL sat: got %b/%b want %b/%b", sat0, sat1, e.s0, e.s1);
        end
        @(posedge clk); #1; n++;
        nchk++;
        if (leader !== e.lead) begin
          nerr++; $display("FAIL leader: got %b want %b", leader, e.lead);
        end
        nchk++;
        if (busy !== 1'b0 || done !== e.dn) begin
          nerr++; $display("FAIL idle_done: busy=%b done=%b want 0 %b", busy, done, e.dn);
        end
        if (sb.size() > 0) due = n + (sb[0].skip ? 2 : 3);
      end else begin
        nchk++;
        if (busy !== 1'b1) begin
          nerr++; $display("FAIL busy_wait: got %b want 1 at cycle %0d", busy, n);
        end
      end
    end
    if (sb.size() > 0) begin
      nchk++; nerr++;
      $display("FAIL timeout: %0d acks missing want 0", sb.size());
      sb.delete();
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nchk++;
    if (total0 !== 0 || total1 !== 0 || count0 !== 0 || count1 !== 0) begin
      nerr++; $display("FAIL reset_data: got %h %h %0d %0d want 0", total0, total1, count0, count1);
    end
    nchk++;
    if (sat0 !== 0 || sat1 !== 0 || leader !== 2'b00 || busy !== 0 || done !== 0
        || bus.ack0 !== 0 || bus.ack1 !== 0) begin
      nerr++; $display("FAIL reset_ctrl: sat %b%b lead %b busy %b done %b want all 0",
                       sat0, sat1, leader, busy, done);
    end
    serve(1'b1, 1'b0, 15'd250, 15'd0);
    // Asynchronous reset in the middle of an ADD.
    bus.req0 = 1'b1; bus.time0 = 15'd9;
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b1;
    #1;
    nchk++;
    if (busy !== 0 || total0 !== 0 || count0 !== 0 || leader !== 2'b00 || bus.ack0 !== 0) begin
      nerr++; $display("FAIL reset_mid: busy %b total0 %h count0 %0d lead %b want 0", busy, total0, count0, leader);
    end
    @(posedge clk); #1;
    reset = 1'b0; bus.req0 = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    do_reset();
    serve(1'b1, 1'b0, 15'd250, 15'd0);
    serve(1'b0, 1'b1, 15'd0, 15'd100);
  endtask

  task automatic test_both();
    do_reset();
    serve(1'b1, 1'b1, 15'd300, 15'd200);
    serve(1'b1, 1'b0, 15'd5, 15'd0);
    serve(1'b1, 1'b1, 15'd7, 15'd8);
  endtask

  task automatic test_saturate();
    do_reset();
    serve(1'b1, 1'b0, 15'h7F00, 15'd0);
    serve(1'b1, 1'b0, 15'h00FF, 15'd0);
    serve(1'b1, 1'b0, 15'h0200, 15'd0);
    serve(1'b1, 1'b0, 15'd5, 15'd0);
  endtask

  task automatic test_tie();
    do_reset();
    serve(1'b1, 1'b1, 15'd400, 15'd400);
    serve(1'b1, 1'b0, 15'd1, 15'd0);
  endtask

  task automatic test_rounds();
    do_reset();
    for (int i = 0; i < MAXR; i++)
      serve(1'b1, 1'b1, 15'(10 + i), 15'(20 + i));
    nchk++;
    if (done !== 1'b1) begin
      nerr++; $display("FAIL done_set: got %b want 1", done);
    end
    serve(1'b1, 1'b0, 15'd99, 15'd0);
    serve(1'b0, 1'b1, 15'd0, 15'd3);
  endtask

  task automatic test_clear();
    do_reset();
    serve(1'b1, 1'b0, 15'd250, 15'd0);
    bus.req1 = 1'b1; bus.time1 = 15'd77;
    @(posedge clk); #1;
    @(posedge clk); #1;
    nchk++;
    if (bus.ack1 !== 1'b0 || busy !== 1'b1) begin
      nerr++; $display("FAIL clear_pre: ack1 %b busy %b want 0 1", bus.ack1, busy);
    end
    clear = 1'b1;
    @(posedge clk); #1;
    nchk++;
    if (bus.ack1 !== 0 || busy !== 0 || total0 !== 0 || count0 !== 0 || leader !== 2'b00
        || sat0 !== 0 || done !== 0) begin
      nerr++; $display("FAIL clear_zero: ack1 %b busy %b total0 %h count0 %0d lead %b want 0",
                       bus.ack1, busy, total0, count0, leader);
    end
    // Clear held with req1 still pending: no grant this cycle.
    @(posedge clk); #1;
    nchk++;
    if (busy !== 1'b0) begin
      nerr++; $display("FAIL clear_req: busy %b want 0", busy);
    end
    clear = 1'b0;
    model_reset();
    serve(1'b0, 1'b1, 15'd0, 15'd77);
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.time0 = '0; bus.time1 = '0;
    model_reset();
    test_reset();
    test_single();
    test_both();
    test_saturate();
    test_tie();
    test_rounds();
    test_clear();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
